// File: rtl/seq_arith_32b_byteserial_add.sv
// Byte-serial W-bit adder: one 8-bit slice plus a registered carry, iterated NBYTES times,
// with val/rdy handshakes on operand and result streams.
module seq_arith_32b_byteserial_add #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                istream_val,
  output logic                istream_rdy,
  input  logic [8*NBYTES-1:0] istream_in0,
  input  logic [8*NBYTES-1:0] istream_in1,
  output logic                ostream_val,
  input  logic                ostream_rdy,
  output logic [8*NBYTES-1:0] ostream_sum,
  output logic                ostream_cout,
  output logic                ostream_ovf
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic           carry_reg;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   sum_reg;
  logic           cout_reg;
  logic           ovf_reg;
  logic           rdy_reg;
  logic           val_reg;

  logic [7:0]     a_bytes [NBYTES];
  logic [7:0]     b_bytes [NBYTES];
  logic [7:0]     a_byte;
  logic [7:0]     b_byte;
  logic [8:0]     slice_sum;
  logic           last_byte;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign a_bytes[gi] = a_reg[8*gi +: 8];
      assign b_bytes[gi] = b_reg[8*gi +: 8];
    end
  endgenerate

  assign a_byte    = a_bytes[cnt_reg];
  assign b_byte    = b_bytes[cnt_reg];
  assign slice_sum = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_reg};
  assign last_byte = (cnt_reg == CW'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      rdy_reg   <= 1'b1;
      val_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (istream_val && rdy_reg) begin
            a_reg     <= istream_in0;
            b_reg     <= istream_in1;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            rdy_reg   <= 1'b0;
            state_reg <= CALC;
          end
        end
        CALC: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (cnt_reg == CW'(i)) sum_reg[8*i +: 8] <= slice_sum[7:0];
          end
          carry_reg <= slice_sum[8];
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_byte) begin
            cout_reg  <= slice_sum[8];
            // Signed overflow: like-signed operands produced a result of the other sign.
            ovf_reg   <= (a_reg[W-1] == b_reg[W-1]) && (slice_sum[7] != a_reg[W-1]);
            val_reg   <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (ostream_rdy) begin
            val_reg   <= 1'b0;
            rdy_reg   <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          rdy_reg   <= 1'b1;
          val_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags are masked so nothing is advertised while reset is held.
  assign istream_rdy  = rdy_reg && !reset;
  assign ostream_val  = val_reg && !reset;
  assign ostream_sum  = sum_reg;
  assign ostream_cout = cout_reg;
  assign ostream_ovf  = ovf_reg;
endmodule

// File: tb/tb_seq_arith_32b_byteserial_add.sv
// Directed bench for the byte-serial adder: reset, corner sums, backpressure,
// mid-operation reset and a back-to-back stream against a 33-bit golden add.
module tb_seq_arith_32b_byteserial_add;
  logic        clk = 1'b0;
  logic        reset;
  logic        istream_val;
  logic        istream_rdy;
  logic [31:0] istream_in0;
  logic [31:0] istream_in1;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [31:0] ostream_sum;
  logic        ostream_cout;
  logic        ostream_ovf;

  int total = 0;
  int bad   = 0;

  seq_arith_32b_byteserial_add #(.NBYTES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .istream_val  (istream_val),
    .istream_rdy  (istream_rdy),
    .istream_in0  (istream_in0),
    .istream_in1  (istream_in1),
    .ostream_val  (ostream_val),
    .ostream_rdy  (ostream_rdy),
    .ostream_sum  (ostream_sum),
    .ostream_cout (ostream_cout),
    .ostream_ovf  (ostream_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers an operand pair, then counts edges after acceptance until ostream_val.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit ok);
    int w;
    ok  = 1'b0;
    lat = 0;
    istream_in0 = a;
    istream_in1 = b;
    istream_val = 1'b1;
    w = 0;
    while (!istream_rdy && w < 20) begin
      tick();
      w++;
    end
    if (!istream_rdy) return;
    tick();
    istream_val = 1'b0;
    istream_in0 = ~a;
    istream_in1 = 32'h5A5A_A5A5;
    while (!ostream_val && lat < 20) begin
      tick();
      lat++;
    end
    ok = ostream_val;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    istream_val = 1'b0;
    ostream_rdy = 1'b0;
    istream_in0 = '0;
    istream_in1 = '0;
    tick();
    tick();
    total++;
    if (istream_rdy !== 1'b0 || ostream_val !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: rdy=%b val=%b required rdy=0 val=0", istream_rdy, ostream_val);
    end
    total++;
    if (ostream_sum !== 32'h0 || ostream_cout !== 1'b0 || ostream_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: sum=%h cout=%b ovf=%b required 0/0/0", ostream_sum, ostream_cout, ostream_ovf);
    end
    reset = 1'b0;
    #1;
    total++;
    if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: rdy=%b val=%b required rdy=1 val=0", istream_rdy, ostream_val);
    end
    $display("test_reset: checked");
  endtask

  task automatic test_basic();
    int lat;
    bit ok;
    bit rdy_seen_high;
    ostream_rdy = 1'b1;
    istream_in0 = 32'h0000_00FF;
    istream_in1 = 32'h0000_0001;
    istream_val = 1'b1;
    tick();                       // accept edge (ready already high)
    istream_val = 1'b1;           // keep offering: must be ignored while busy
    lat = 0;
    rdy_seen_high = 1'b0;
    while (!ostream_val && lat < 20) begin
      if (istream_rdy) rdy_seen_high = 1'b1;
      tick();
      lat++;
    end
    ok = ostream_val;
    if (istream_rdy) rdy_seen_high = 1'b1;
    istream_val = 1'b0;
    total++;
    if (!ok || lat != 4) begin
      bad++;
      $display("FAIL basic_latency: edges_to_val=%0d required 4", lat);
    end
    total++;
    if (rdy_seen_high) begin
      bad++;
      $display("FAIL basic_rdy_busy: istream_rdy=1 seen while busy required 0");
    end
    total++;
    if (ostream_sum !== 32'h0000_0100 || ostream_cout !== 1'b0 || ostream_ovf !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: sum=%h cout=%b ovf=%b required 00000100/0/0",
               ostream_sum, ostream_cout, ostream_ovf);
    end
    tick();                       // output transfer
    total++;
    if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
      bad++;
      $display("FAIL basic_after_xfer: rdy=%b val=%b required rdy=1 val=0", istream_rdy, ostream_val);
    end
    $display("test_basic: 000000ff+00000001 sum=%h lat=%0d", ostream_sum, lat);
  endtask

  task automatic test_corners();
    logic [31:0] va [5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_002A, 32'h1234_5678};
    logic [31:0] vb [5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFF3, 32'h1111_1111};
    logic [31:0] vs [5] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_001D, 32'h2345_6789};
    logic        vc [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    bit ok;
    ostream_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], lat, ok);
      total++;
      if (!ok || ostream_sum !== vs[i] || ostream_cout !== vc[i] || ostream_ovf !== vo[i]) begin
        bad++;
        $display("FAIL corner_%0d: ok=%b sum=%h cout=%b ovf=%b required %h/%b/%b",
                 i, ok, ostream_sum, ostream_cout, ostream_ovf, vs[i], vc[i], vo[i]);
      end
      $display("test_corners: %h+%h sum=%h cout=%b ovf=%b", va[i], vb[i], ostream_sum, ostream_cout, ostream_ovf);
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    ostream_rdy = 1'b0;
    do_op(32'h7FFF_FFFF, 32'h0000_0001, lat, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_timeout: ostream_val never rose required 1");
    end
    istream_val = 1'b1;
    istream_in0 = 32'h0000_0003;
    istream_in1 = 32'h0000_0004;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ostream_val !== 1'b1 || istream_rdy !== 1'b0 || ostream_sum !== 32'h8000_0000 ||
          ostream_cout !== 1'b0 || ostream_ovf !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold_%0d: val=%b rdy=%b sum=%h cout=%b ovf=%b required 1/0/80000000/0/1",
                 i, ostream_val, istream_rdy, ostream_sum, ostream_cout, ostream_ovf);
      end
    end
    istream_val = 1'b0;
    ostream_rdy = 1'b1;
    tick();
    total++;
    if (ostream_val !== 1'b0 || istream_rdy !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: val=%b rdy=%b required val=0 rdy=1", ostream_val, istream_rdy);
    end
    $display("test_backpressure: held 3 cycles, released");
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ok;
    bit stale;
    ostream_rdy = 1'b1;
    istream_in0 = 32'hDEAD_BEEF;
    istream_in1 = 32'h0101_0101;
    istream_val = 1'b1;
    tick();                       // accept
    istream_val = 1'b0;
    tick();
    tick();                       // two CALC edges done
    reset = 1'b1;
    #1;
    total++;
    if (istream_rdy !== 1'b0 || ostream_val !== 1'b0) begin
      bad++;
      $display("FAIL midreset_during: rdy=%b val=%b required 0/0", istream_rdy, ostream_val);
    end
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
      bad++;
      $display("FAIL midreset_after: rdy=%b val=%b required rdy=1 val=0", istream_rdy, ostream_val);
    end
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ostream_val) stale = 1'b1;
    end
    total++;
    if (stale) begin
      bad++;
      $display("FAIL midreset_stale: ostream_val=1 after abandoned op required 0");
    end
    do_op(32'h1234_5678, 32'h1111_1111, lat, ok);
    total++;
    if (!ok || ostream_sum !== 32'h2345_6789 || ostream_cout !== 1'b0 || ostream_ovf !== 1'b0) begin
      bad++;
      $display("FAIL midreset_next: ok=%b sum=%h cout=%b ovf=%b required 23456789/0/0",
               ok, ostream_sum, ostream_cout, ostream_ovf);
    end
    $display("test_reset_mid: 12345678+11111111 sum=%h", ostream_sum);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp_q [$];
    logic [32:0] wide;
    logic [33:0] exp;
    int sent = 0;
    int got = 0;
    int last_cyc = -1;
    int cyc = 0;
    ostream_rdy = 1'b1;
    istream_in0 = $urandom;
    istream_in1 = $urandom;
    istream_val = 1'b1;
    while (got < 20 && cyc < 400) begin
      if (ostream_val) begin
        exp = exp_q.pop_front();
        total++;
        if ({ostream_ovf, ostream_cout, ostream_sum} !== exp) begin
          bad++;
          $display("FAIL b2b_result_%0d: sum=%h cout=%b ovf=%b required %h/%b/%b",
                   got, ostream_sum, ostream_cout, ostream_ovf, exp[31:0], exp[32], exp[33]);
        end
        if (last_cyc >= 0) begin
          total++;
          if (cyc - last_cyc != 6) begin
            bad++;
            $display("FAIL b2b_spacing_%0d: cycles=%0d required 6", got, cyc - last_cyc);
          end
        end
        $display("test_back_to_back: result %0d sum=%h cout=%b ovf=%b", got, ostream_sum, ostream_cout, ostream_ovf);
        last_cyc = cyc;
        got++;
      end
      if (istream_val && istream_rdy) begin
        wide = {1'b0, istream_in0} + {1'b0, istream_in1};
        exp_q.push_back({(istream_in0[31] == istream_in1[31]) && (wide[31] != istream_in0[31]),
                         wide[32], wide[31:0]});
        sent++;
        tick();
        if (sent == 20) begin
          istream_val = 1'b0;
        end else begin
          istream_in0 = $urandom;
          istream_in1 = $urandom;
        end
      end else begin
        tick();
      end
      cyc++;
    end
    istream_val = 1'b0;
    total++;
    if (got != 20) begin
      bad++;
      $display("FAIL b2b_count: results=%0d required 20", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
